// File: rtl/com_uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : com_uart_rx_pkg
// Description : Shared UART constants, receiver state encoding and helper
//               functions for the com register-link serial blocks. The
//               oversampling constants and divider helper are also used by
//               the transmit side.
// Contents    : OVERSAMPLE, vote sample indices, DATA_BITS, rx_state_e,
//               calc_div(), maj3()
// Revision    : 1.0 - initial release
// ============================================================================
package com_uart_rx_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    // Samples taken inside each bit period for the 3-way majority vote.
    // The bit is resolved at the end of SMP_VOTE_C.
    localparam logic [3:0] SMP_VOTE_A = 4'd7;
    localparam logic [3:0] SMP_VOTE_B = 4'd8;
    localparam logic [3:0] SMP_VOTE_C = 4'd9;
    localparam logic [3:0] SMP_LAST   = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

    // Oversample divider, integer-truncated.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/com_fifo.sv
`default_nettype none
// ============================================================================
// Module      : com_fifo
// Description : Synchronous show-ahead FIFO. rd_data is always the head
//               entry. A push while full is only accepted when a pop happens
//               in the same cycle; there is no empty bypass, so a byte pushed
//               into an empty FIFO becomes visible the following cycle.
// Ports       : clk      - clock, rising edge
//               rst_n    - synchronous active-low reset
//               push     - write request, wr_data is stored when accepted
//               wr_data  - write data
//               pop      - remove head entry (ignored when empty)
//               rd_data  - head entry
//               full     - DEPTH entries stored
//               empty    - no entries stored
// Revision    : 1.0 - initial release
// ============================================================================
module com_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4     // power of two, >= 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit separates full from empty; pointers wrap
    // modulo 2*DEPTH.
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign do_pop  = pop && !empty;
    // When full, the slot being freed by a simultaneous pop is the one the
    // write pointer addresses, so both can proceed.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            // Cleared so the head output reads zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
                wr_ptr                  <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/com_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : com_uart_rx
// Description : 8N1 UART receive front end. 2-FF synchronizer, 16x
//               oversampling tick generator, 3-sample majority vote per bit,
//               byte FIFO with valid/ready output, framing-error and overrun
//               pulses.
// Ports       : CLK       - system clock, rising edge
//               RST_N     - synchronous active-low reset
//               RX        - asynchronous serial line, idles high
//               DATA      - byte at FIFO head
//               VALID     - FIFO not empty
//               READY     - consumer accepts head byte when VALID && READY
//               FRAME_ERR - one-cycle pulse, stop bit sampled low
//               OVERRUN   - one-cycle pulse, good byte dropped (FIFO full)
// Revision    : 1.0 - initial release
// ============================================================================
module com_uart_rx
    import com_uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RX,
    output logic [7:0] DATA,
    output logic       VALID,
    input  logic       READY,
    output logic       FRAME_ERR,
    output logic       OVERRUN
);

    localparam int                DIV       = calc_div(CLK_HZ, BAUD);
    localparam int                TICK_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Synchronizer and start qualification
    // ------------------------------------------------------------------
    logic       sync_1;
    logic       rx_s;
    logic       prev_s;
    logic [1:0] settle;
    logic       armed;

    // The sync flops reset to 1, so the first real line value reaches rx_s
    // two cycles after reset. If RX is held low through reset that would look
    // like a falling edge; 'armed' requires the real line to be seen high
    // before any start is accepted.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
            prev_s <= 1'b1;
            settle <= 2'd0;
            armed  <= 1'b0;
        end else begin
            sync_1 <= RX;
            rx_s   <= sync_1;
            prev_s <= rx_s;
            if (settle != 2'd2) begin
                settle <= settle + 2'd1;
            end
            if (settle == 2'd2 && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM control signals
    // ------------------------------------------------------------------
    rx_state_e state;
    rx_state_e state_nx;
    logic      clr_cnt;
    logic      shift_en;
    logic      bit_inc;
    logic      push_req;
    logic      ferr_set;

    // ------------------------------------------------------------------
    // Tick generator, sample counter, bit index
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [3:0]        sample_cnt;
    logic [2:0]        bit_idx;
    logic              vote_a;
    logic              vote_b;
    logic              bit_vote;
    logic              at_vote;
    logic              at_end;

    assign tick     = (tick_cnt == TICK_LAST);
    assign at_vote  = tick && (sample_cnt == SMP_VOTE_C);
    assign at_end   = tick && (sample_cnt == SMP_LAST);
    // Third vote is the live sample on the resolving tick.
    assign bit_vote = maj3(vote_a, vote_b, rx_s);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            tick_cnt   <= '0;
            sample_cnt <= 4'd0;
            bit_idx    <= 3'd0;
            vote_a     <= 1'b1;
            vote_b     <= 1'b1;
        end else if (clr_cnt) begin
            tick_cnt   <= '0;
            sample_cnt <= 4'd0;
            bit_idx    <= 3'd0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                sample_cnt <= sample_cnt + 4'd1;
                if (sample_cnt == SMP_VOTE_A) begin
                    vote_a <= rx_s;
                end
                if (sample_cnt == SMP_VOTE_B) begin
                    vote_b <= rx_s;
                end
            end
            if (bit_inc) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shift register, LSB first
    // ------------------------------------------------------------------
    logic [7:0] shreg;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            shreg <= 8'h00;
        end else if (shift_en) begin
            shreg <= {bit_vote, shreg[7:1]};
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        clr_cnt  = 1'b0;
        shift_en = 1'b0;
        bit_inc  = 1'b0;
        push_req = 1'b0;
        ferr_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (armed && prev_s && !rx_s) begin
                    clr_cnt  = 1'b1;
                    state_nx = ST_START;
                end
            end
            ST_START: begin
                if (at_vote && bit_vote) begin
                    state_nx = ST_IDLE;         // false start
                end else if (at_end) begin
                    state_nx = ST_DATA;         // bit_idx is already 0
                end
            end
            ST_DATA: begin
                if (at_vote) begin
                    shift_en = 1'b1;
                end
                if (at_end) begin
                    if (bit_idx == LAST_BIT) begin
                        state_nx = ST_STOP;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                // Leave at the vote so a short stop bit is tolerated.
                if (at_vote) begin
                    if (bit_vote) begin
                        push_req = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_nx = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // A held break only produces one error, never repeated bytes.
                if (rx_s) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Byte FIFO and status pulses
    // ------------------------------------------------------------------
    logic fifo_full;
    logic fifo_empty;
    logic pop;

    assign VALID = !fifo_empty;
    assign pop   = VALID && READY;

    com_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .push    (push_req),
        .wr_data (shreg),
        .pop     (pop),
        .rd_data (DATA),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            FRAME_ERR <= ferr_set;
            OVERRUN   <= push_req && fifo_full && !pop;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_com_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_com_uart_rx
// Description : Self-checking bench for com_uart_rx. Frames are driven at the
//               pin; a queue-based model predicts VALID/DATA/FRAME_ERR/OVERRUN
//               every cycle from the frame arrival times and READY.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_com_uart_rx;

    // Small divider keeps the run short; 770000/(9600*16) truncates to 5.
    localparam int CLK_HZ     = 770000;
    localparam int BAUD       = 9600;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV        = CLK_HZ / (BAUD * 16);
    localparam int BITC       = 16 * DIV;
    localparam int LAT        = 154 * DIV + 3;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       rx        = 1'b1;
    logic       ready_man = 1'b0;
    logic       rand_mode = 1'b0;
    logic       rnd_bit   = 1'b0;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    assign ready = rand_mode ? rnd_bit : ready_man;

    com_uart_rx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .RX        (rx),
        .DATA      (data),
        .VALID     (valid),
        .READY     (ready),
        .FRAME_ERR (frame_err),
        .OVERRUN   (overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: frame completion events + byte queue
    // ------------------------------------------------------------------
    typedef struct {
        int         edge_no;
        logic [7:0] b;
        bit         good;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] mq[$];
    logic       exp_valid    = 1'b0;
    logic       exp_ovr      = 1'b0;
    logic       exp_ferr     = 1'b0;
    logic [7:0] exp_data     = 8'h00;
    bit         data_rst_chk = 1'b1;
    bit         chk_en       = 1'b0;
    int         n_ovr_exp    = 0;
    int         n_ferr_exp   = 0;
    int         n_ovr_seen   = 0;
    int         n_ferr_seen  = 0;

    always begin
        @(posedge clk);
        begin
            ev_t e;
            int  sz;
            bit  pop;
            cyc      = cyc + 1;
            exp_ovr  = 1'b0;
            exp_ferr = 1'b0;
            if (!rst_n) begin
                mq.delete();
                ev_q.delete();
                data_rst_chk = 1'b1;
            end else begin
                sz  = mq.size();
                pop = ready && (sz > 0);
                if (pop) void'(mq.pop_front());
                while (ev_q.size() > 0 && ev_q[0].edge_no < cyc) void'(ev_q.pop_front());
                if (ev_q.size() > 0 && ev_q[0].edge_no == cyc) begin
                    e = ev_q.pop_front();
                    if (!e.good) begin
                        exp_ferr = 1'b1;
                        n_ferr_exp++;
                    end else if (sz == FIFO_DEPTH && !pop) begin
                        exp_ovr = 1'b1;
                        n_ovr_exp++;
                    end else begin
                        mq.push_back(e.b);
                        data_rst_chk = 1'b0;
                    end
                end
            end
            exp_valid = (mq.size() > 0);
            if (exp_valid) exp_data = mq[0];
        end
    end

    // Per-cycle comparison, away from the active edge.
    always begin
        @(negedge clk);
        if (chk_en) begin
            check("valid", 32'(valid), 32'(exp_valid));
            check("overrun", 32'(overrun), 32'(exp_ovr));
            check("frame_err", 32'(frame_err), 32'(exp_ferr));
            if (exp_valid) check("data", 32'(data), 32'(exp_data));
            else if (data_rst_chk) check("data_rst", 32'(data), 32'h0);
            if (overrun === 1'b1) n_ovr_seen++;
            if (frame_err === 1'b1) n_ferr_seen++;
        end
    end

    // Sparse random READY so the FIFO sometimes fills.
    always begin
        @(negedge clk);
        rnd_bit = ($urandom_range(0, 511) == 0);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge with the line idle high. stop_low_bits > 0 holds
    // the stop bit low for that many bit times (framing error).
    task automatic send_frame(input logic [7:0] b, input int stop_low_bits);
        ev_t e;
        e.edge_no = cyc + 3 + 154 * DIV;
        e.b       = b;
        e.good    = (stop_low_bits == 0);
        ev_q.push_back(e);
        rx = 1'b0;
        wait_neg(BITC);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_neg(BITC);
        end
        if (stop_low_bits > 0) begin
            rx = 1'b0;
            wait_neg(stop_low_bits * BITC);
        end
        rx = 1'b1;
        wait_neg(BITC);
    endtask

    task automatic drain_expect(input logic [7:0] first, input int n);
        ready_man = 1'b1;
        for (int i = 0; i < n; i++) begin
            check("drain_valid", 32'(valid), 32'h1);
            check("drain_data", 32'(data), 32'(first + 8'(i)));
            wait_neg(1);
        end
        check("drain_empty", 32'(valid), 32'h0);
        ready_man = 1'b0;
    endtask

    initial begin
        int fall;
        int p;

        rst_n = 1'b0;
        rx    = 1'b1;
        wait_neg(4);
        rst_n = 1'b1;
        wait_neg(4);
        chk_en = 1'b1;
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_data", 32'(data), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);

        // Single frame, exact pin-to-VALID latency.
        fall = cyc;
        fork
            send_frame(8'hA5, 0);
            begin
                int k = 0;
                while (valid !== 1'b1 && k < 2 * LAT) begin
                    wait_neg(1);
                    k++;
                end
                check("latency", 32'(cyc - fall), 32'(LAT));
                check("a5_data", 32'(data), 32'hA5);
            end
        join
        drain_expect(8'hA5, 1);

        // Short low glitch: false start, nothing produced.
        rx = 1'b0;
        wait_neg(3 * DIV);
        rx = 1'b1;
        wait_neg(2 * BITC);
        check("glitch_valid", 32'(valid), 32'h0);

        // Framing error then a good byte.
        send_frame(8'h3C, 2);
        check("ferr_seen", 32'(n_ferr_seen), 32'h1);
        check("ferr_novalid", 32'(valid), 32'h0);
        wait_neg(BITC);
        send_frame(8'h11, 0);
        drain_expect(8'h11, 1);

        // Fill and overrun on byte 5; drain on consecutive cycles.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0);
        wait_neg(4);
        check("ovr_once", 32'(n_ovr_seen), 32'h1);
        drain_expect(8'h01, 4);

        // Full FIFO, READY exactly on the stop-decision cycle.
        for (int i = 7; i <= 10; i++) send_frame(8'(i), 0);
        p = cyc;
        fork
            send_frame(8'h0B, 0);
            begin
                wait_neg(2 + 154 * DIV);
                ready_man = 1'b1;
                wait_neg(1);
                ready_man = 1'b0;
            end
        join
        check("no_ovr_on_pop", 32'(n_ovr_seen), 32'h1);
        check("tail_wait", 32'(cyc - p), 32'(10 * BITC));
        drain_expect(8'h08, 4);

        // Reset pulse mid-data-bit with RX low: FIFO content and frame lost.
        send_frame(8'h55, 0);
        rx = 1'b0;
        wait_neg(BITC + BITC / 2);
        rst_n = 1'b0;
        wait_neg(1);
        rst_n = 1'b1;
        check("rst_mid_valid", 32'(valid), 32'h0);
        wait_neg(12 * BITC);
        rx = 1'b1;
        wait_neg(2 * BITC);
        check("rst_mid_nobyte", 32'(valid), 32'h0);
        send_frame(8'h7E, 0);
        drain_expect(8'h7E, 1);

        // Randomized frames, gaps, occasional framing errors, sparse READY.
        rand_mode = 1'b1;
        for (int n = 0; n < 14; n++) begin
            logic [7:0] b;
            b = 8'($urandom);
            send_frame(b, ($urandom_range(0, 5) == 0) ? 1 : 0);
            wait_neg($urandom_range(0, BITC));
        end
        rand_mode = 1'b0;
        ready_man = 1'b1;
        wait_neg(10);
        ready_man = 1'b0;
        check("final_empty", 32'(valid), 32'h0);
        check("ovr_total", 32'(n_ovr_seen), 32'(n_ovr_exp));
        check("ferr_total", 32'(n_ferr_seen), 32'(n_ferr_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
